// File: rtl/md_unit_pkg.sv
// ============================================================================
//  Module      : md_unit_pkg
//  Description : Shared op codes, FSM state encodings and helpers for the
//                HI/LO multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package md_unit_pkg;

   // Operation codes presented on the op port; 6 and 7 are reserved no-ops
   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   // Two-state controller encoding
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   // Larger of two integers, used to size the latency counter
   function automatic int md_max(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
//  Module      : md_unit
//  Description : Multi-cycle multiply/divide unit with HI/LO registers.
//                The result is computed at accept time into shadow registers
//                and published to HI/LO only when the busy window expires.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit
   import md_unit_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int                 c_CNT_W    = $clog2(md_max(MUL_CYCLES, DIV_CYCLES)) + 1;
   localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_CYCLES);
   localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_CYCLES);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   logic [0:0]         r_state;
   logic [0:0]         w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]   r_shadow_hi;
   logic [WIDTH-1:0]   r_shadow_lo;
   logic               r_shadow_wr;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_accept_md;
   logic               w_mthi;
   logic               w_mtlo;
   logic               w_last;

   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;
   logic               w_res_wr;
   logic [c_CNT_W-1:0] w_res_cnt;

   // Products: sign-extend to full product width for MULT, zero-extend for MULTU
   logic [2*WIDTH-1:0] w_prod_s;
   logic [2*WIDTH-1:0] w_prod_u;
   assign w_prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
   assign w_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   // Signed divide via magnitudes; the most negative dividend's magnitude
   // still fits unsigned, so MIN / -1 naturally yields MIN with remainder 0
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH-1:0] w_q_mag;
   logic [WIDTH-1:0] w_r_mag;
   assign w_a_neg = a[WIDTH-1];
   assign w_b_neg = b[WIDTH-1];
   assign w_a_mag = w_a_neg ? -a : a;
   assign w_b_mag = w_b_neg ? -b : b;
   assign w_q_mag = w_a_mag / w_b_mag;
   assign w_r_mag = w_a_mag % w_b_mag;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state: launch multi-cycle ops from IDLE, return when the count expires
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept_md) w_state_nxt = S_BUSY;
         S_BUSY:  if (w_last)      w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Controller outputs: busy flag, accept/move strobes and completion strobe
   always_comb begin
      busy        = (r_state == S_BUSY);
      w_last      = (r_state == S_BUSY) && (r_cnt == c_CNT_ONE);
      w_accept_md = 1'b0;
      w_mthi      = 1'b0;
      w_mtlo      = 1'b0;
      if ((r_state == S_IDLE) && start) begin
         case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: w_accept_md = 1'b1;
            MD_MTHI: w_mthi = 1'b1;
            MD_MTLO: w_mtlo = 1'b1;
            default: ;
         endcase
      end
   end

   // Result selection for the op being accepted; divide by zero suppresses the write
   always_comb begin
      w_res_hi  = '0;
      w_res_lo  = '0;
      w_res_wr  = 1'b1;
      w_res_cnt = c_MUL_LOAD;
      case (op)
         MD_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
         MD_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
         MD_DIV: begin
            w_res_cnt = c_DIV_LOAD;
            w_res_wr  = (b != '0);
            w_res_lo  = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
            w_res_hi  = w_a_neg ? -w_r_mag : w_r_mag;
         end
         MD_DIVU: begin
            w_res_cnt = c_DIV_LOAD;
            w_res_wr  = (b != '0);
            w_res_lo  = a / b;
            w_res_hi  = a % b;
         end
         default: w_res_wr = 1'b0;
      endcase
   end

   // Datapath: shadow capture at accept, countdown, publish at completion or MT*
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_shadow_hi <= '0;
         r_shadow_lo <= '0;
         r_shadow_wr <= 1'b0;
         r_hi        <= '0;
         r_lo        <= '0;
      end else begin
         if (w_accept_md) begin
            r_cnt       <= w_res_cnt;
            r_shadow_hi <= w_res_hi;
            r_shadow_lo <= w_res_lo;
            r_shadow_wr <= w_res_wr;
         end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - c_CNT_ONE;
         end
         if (w_last && r_shadow_wr) begin
            r_hi <= r_shadow_hi;
            r_lo <= r_shadow_lo;
         end
         if (w_mthi) r_hi <= a;
         if (w_mtlo) r_lo <= a;
      end
   end

   assign hi = r_hi;
   assign lo = r_lo;

endmodule

`default_nettype wire
